pc_mux: RTL and testbench



---
 rtl/pc_mux.sv | 57 +++++
 tb/tb_pc_mux.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/pc_mux.sv
// Next-PC select for instruction fetch: picks PC+4 or the EX/MEM target,
// exposes the choice combinationally and holds it in a registered PC.
module pc_mux #(
  parameter int unsigned WIDTH                  = 8,
  parameter int unsigned IN1_WIDTH              = 32,
  parameter logic [WIDTH-1:0] RESET_PC          = '0
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     in0,
  input  logic [IN1_WIDTH-1:0] in1,
  input  logic                 sel,
  input  logic                 en,
  output logic [WIDTH-1:0]     out,
  output logic [WIDTH-1:0]     pc,
  output logic                 redirect,
  output logic                 misaligned
);

  // Only the low WIDTH bits of the EX/MEM target address instruction memory.
  logic [WIDTH-1:0] in1_trunc;
  assign in1_trunc = in1[WIDTH-1:0];

  generate
    if (IN1_WIDTH > WIDTH) begin : g_in1_hi
      logic unused_in1_hi;
      assign unused_in1_hi = ^in1[IN1_WIDTH-1:WIDTH];
    end
  endgenerate

  always_comb begin
    out = in0;
    if (sel == 1'b1) out = in1_trunc;
  end

  generate
    if (WIDTH >= 2) begin : g_misaligned
      assign misaligned = |out[1:0];
    end else begin : g_no_misaligned
      assign misaligned = 1'b0;
    end
  endgenerate

  // redirect marks only the cycle after a load that took the branch target.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      redirect <= 1'b0;
    end else if (en) begin
      pc       <= out;
      redirect <= sel;
    end else begin
      redirect <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_mux.sv
// Scoreboard bench for pc_mux: stimulus queues expected outputs, a monitor
// process pops and compares them against the DUT.
module tb_pc_mux;

  logic        clock;
  logic        reset_n;
  logic [7:0]  in0;
  logic [31:0] in1;
  logic        sel;
  logic        en;
  logic [7:0]  out;
  logic [7:0]  pc;
  logic        redirect;
  logic        misaligned;

  pc_mux #(.WIDTH(8), .IN1_WIDTH(32), .RESET_PC(8'h00)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in0       (in0),
    .in1       (in1),
    .sel       (sel),
    .en        (en),
    .out       (out),
    .pc        (pc),
    .redirect  (redirect),
    .misaligned(misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic [7:0] out;
    logic [7:0] pc;
    logic       redirect;
    logic       misaligned;
  } exp_t;

  exp_t q[$];
  event chk;
  int   checks   = 0;
  int   failures = 0;

  always begin
    @(chk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (out !== e.out || pc !== e.pc || redirect !== e.redirect ||
          misaligned !== e.misaligned) begin
        failures++;
        $display("FAIL %s: got out=%h pc=%h redirect=%b misaligned=%b, want out=%h pc=%h redirect=%b misaligned=%b",
                 e.name, out, pc, redirect, misaligned,
                 e.out, e.pc, e.redirect, e.misaligned);
      end
    end
  end

  task automatic expect_now(input string name, input logic [7:0] o,
                            input logic [7:0] p, input logic r, input logic m);
    exp_t e;
    e.name = name; e.out = o; e.pc = p; e.redirect = r; e.misaligned = m;
    q.push_back(e);
    -> chk;
    #0;
  endtask

  task automatic drive(input logic [7:0] a, input logic [31:0] b,
                       input logic s, input logic e);
    in0 = a; in1 = b; sel = s; en = e;
  endtask

  task automatic edge_step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(8'h00, 32'h40, 1'b1, 1'b1);
    #1;
    expect_now("reset_async", 8'h40, 8'h00, 1'b0, 1'b0);
    edge_step();
    expect_now("reset_held_edge", 8'h40, 8'h00, 1'b0, 1'b0);

    @(negedge clock);
    reset_n = 1'b1;
    drive(8'h04, 32'h40, 1'b0, 1'b1);
    #1;
    expect_now("seq_comb", 8'h04, 8'h00, 1'b0, 1'b0);
    edge_step();
    expect_now("seq_load", 8'h04, 8'h04, 1'b0, 1'b0);

    @(negedge clock);
    drive(8'h04, 32'hDEAD_BE20, 1'b1, 1'b1);
    #1;
    expect_now("branch_comb", 8'h20, 8'h04, 1'b0, 1'b0);
    edge_step();
    expect_now("branch_load", 8'h20, 8'h20, 1'b1, 1'b0);

    @(negedge clock);
    drive(8'h04, 32'h80, 1'b1, 1'b0);
    #1;
    expect_now("hold_comb", 8'h80, 8'h20, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      edge_step();
      expect_now($sformatf("hold_edge%0d", i), 8'h80, 8'h20, 1'b0, 1'b0);
    end

    @(negedge clock);
    drive(8'h06, 32'h80, 1'b0, 1'b1);
    #1;
    expect_now("misalign_comb", 8'h06, 8'h20, 1'b0, 1'b1);
    edge_step();
    expect_now("misalign_load", 8'h06, 8'h06, 1'b0, 1'b1);

    @(negedge clock);
    drive(8'hFC, 32'h0000_01FF, 1'b1, 1'b1);
    #1;
    expect_now("trunc_ff_comb", 8'hFF, 8'h06, 1'b0, 1'b1);
    drive(8'hFC, 32'h0000_01FF, 1'b0, 1'b1);
    #1;
    expect_now("wrap_fc_comb", 8'hFC, 8'h06, 1'b0, 1'b0);
    edge_step();
    expect_now("wrap_fc_load", 8'hFC, 8'hFC, 1'b0, 1'b0);

    @(negedge clock);
    drive(8'h04, 32'h20, 1'b1, 1'b1);
    edge_step();
    expect_now("pre_reset_load", 8'h20, 8'h20, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    expect_now("midrun_reset", 8'h20, 8'h00, 1'b0, 1'b0);
    edge_step();
    expect_now("reset_over_load", 8'h20, 8'h00, 1'b0, 1'b0);

    @(negedge clock);
    reset_n = 1'b1;
    drive(8'h04, 32'h20, 1'b0, 1'b1);
    edge_step();
    expect_now("post_reset_load", 8'h04, 8'h04, 1'b0, 1'b0);

    for (int i = 0; i < 100 && q.size() > 0; i++) #1;
    if (q.size() > 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
